impact_sram_ctrl: RTL and testbench
===================================

Name: impact_sram_ctrl

Overview:
- Digital access sequencer that drives one IMPACTSram 32x32 bank.
- It drives the 32 wordlines (East) and the 32 BL/BLb bitline pairs (West/South) through tri-state control, and senses the bitlines on reads.
- Upstream logic issues single-word read and write requests over a valid/ready handshake.
- Each request runs a fixed precharge → wordline pulse → recovery sequence and returns read data with a one-cycle valid strobe.

Parameters:
- PRE_CYCLES, 2, precharge duration in clocks; legal range 1..15.
- WL_CYCLES, 3, wordline pulse duration in clocks; legal range 1..15.
- ADDR_W, 5, word address width; 2^ADDR_W = 32 wordlines.

Ports:
- wb_clk_i  input  1  single clock, rising edge.
- wb_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle, accepts a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address, selects one wordline.
- req_wdata  input  32  write data.
- rd_valid  output  1  one-cycle strobe; rd_data and rd_err are valid.
- rd_data  output  32  sensed read word.
- rd_err  output  1  at least one bit pair was ambiguous at sense time.
- wl  output  32  one-hot wordline drive, to bank WL0..WL31.
- bl_out  output  32  BL drive value.
- blb_out  output  32  BLb drive value.
- bl_oe  output  1  1 = drive BL/BLb, 0 = release (high-Z at the pad wrapper).
- bl_in  input  32  sensed BL.
- blb_in  input  32  sensed BLb.

Behaviour:
- States: IDLE, PRE, ACCESS, RECOV. All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE, wl = 0, bl_oe = 0, bl_out = 0, blb_out = 0.
  - rd_valid = 0, rd_data = 0, rd_err = 0.
  - Internal latches and counter cleared. req_ready = 1 after reset release.
- req_ready = 1 only in IDLE. Handshake fires when req_valid && req_ready at a clock edge.
  - At that edge: latch req_we, req_addr, req_wdata; load counter = PRE_CYCLES-1; go to PRE.
  - Request inputs are ignored outside IDLE. No queueing; there is a single outstanding request.
- PRE: wl = 0, bl_oe = 1, bl_out = blb_out = all ones.
  - Counter decrements each cycle.
  - At 0: load WL_CYCLES-1 and go to ACCESS.
- ACCESS: wl = 1 << addr; exactly one bit is set.
  - Write: bl_oe = 1, bl_out = wdata, blb_out = ~wdata.
  - Read: bl_oe = 0, bl_out = blb_out = 0.
  - At counter 0 go to RECOV.
  - Read only, at the final ACCESS edge:
    - rd_data[i] <= bl_in[i] & ~blb_in[i].
    - rd_err <= OR over i of ~(bl_in[i] ^ blb_in[i]).
- RECOV: exactly 1 cycle. wl = 0, bl_oe = 0.
  - rd_valid = 1 for this cycle for reads only; writes never assert rd_valid.
  - Next state IDLE.
- Break-before-make invariants:
  - wl != 0 never occurs in the same cycle as precharge (PRE).
  - wl changes never coincide with a bl_oe 0→1 transition.
- Latency from the accepting edge:
  - PRE occupies cycles 1..PRE_CYCLES.
  - ACCESS occupies the next WL_CYCLES cycles.
  - RECOV is cycle PRE_CYCLES+WL_CYCLES+1.
  - req_ready returns the following cycle. Throughput is one request per PRE_CYCLES+WL_CYCLES+2 cycles.
- Holding: rd_data and rd_err hold their values until the next read's sense edge. Writes do not modify them.
- Address wrap: req_addr is used directly with no truncation. ADDR_W=5 maps onto the full 32 wordlines, so no out-of-range value exists.
- Back-to-back: a req_valid held high through RECOV is accepted on the first IDLE cycle. There are no bubbles beyond that.

Test Plan:
- Reset state: assert wb_rst_n=0 mid-ACCESS of a write to addr 7 → in the same cycle wl=0, bl_oe=0, rd_valid=0. After release, req_ready=1 and the next request proceeds normally.
- Write sequence: write addr 5, wdata 0xA5A5_0F0F with defaults (2/3) → each of the following holds for exactly the stated cycles:
  - Cycles 1–2: bl_oe=1, bl_out=blb_out=0xFFFF_FFFF, wl=0.
  - Cycles 3–5: wl=0x0000_0020, bl_out=0xA5A5_0F0F, blb_out=0x5A5A_F0F0.
  - Cycle 6: wl=0, no rd_valid.
  - Cycle 7: req_ready=1.
- Read sequence: read addr 31 with bl_in=0x1234_5678 and blb_in=~bl_in during ACCESS → wl=0x8000_0000 in cycles 3–5 and bl_oe=0 there. rd_valid=1 in cycle 6 only, with rd_data=0x1234_5678 and rd_err=0.
- Ambiguous sense: read with bl_in=blb_in=0xFFFF_FFFF → rd_data=0, rd_err=1. A following clean read clears rd_err to 0.
- Back-to-back and ignored inputs: req_valid held high with write addr 0 then read addr 1 → second accept occurs exactly 7 cycles after the first. req_addr changes during busy cycles have no effect on wl.
- Parameter corner: PRE_CYCLES=1, WL_CYCLES=1 → PRE 1 cycle, ACCESS 1 cycle, rd_valid in cycle 3, and wl is never nonzero while bl_oe is high and bl_out=all ones.

Source files
------------

// File: rtl/impact_sram_ctrl.sv
// Access sequencer for one IMPACTSram 32x32 bank.
// Each request runs precharge, wordline pulse, then a one-cycle recovery. All outputs are registered.
module impact_sram_ctrl #(
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 3,
  parameter int ADDR_W     = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_err,
  output logic [31:0]       wl,
  output logic [31:0]       bl_out,
  output logic [31:0]       blb_out,
  output logic              bl_oe,
  input  logic [31:0]       bl_in,
  input  logic [31:0]       blb_in
);

  typedef enum logic [1:0] {IDLE, PRE, ACCESS, RECOV} state_t;

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [31:0]       wdata_lat;
  logic              accept, sense;

  logic [31:0] wl_next, bl_out_next, blb_out_next;
  logic        bl_oe_next, rd_valid_next, req_ready_next;

  assign accept = req_valid && (state == IDLE);
  assign sense  = (state == ACCESS) && (cnt == 4'd0) && !we_lat;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = PRE;
          cnt_next   = PRE_LOAD;
        end
      end
      PRE: begin
        if (cnt == 4'd0) begin
          state_next = ACCESS;
          cnt_next   = WL_LOAD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_next = RECOV;
        else             cnt_next   = cnt - 4'd1;
      end
      RECOV:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they land in registers aligned with it.
  always_comb begin
    wl_next        = '0;
    bl_out_next    = '0;
    blb_out_next   = '0;
    bl_oe_next     = 1'b0;
    rd_valid_next  = 1'b0;
    req_ready_next = (state_next == IDLE);
    case (state_next)
      PRE: begin
        bl_oe_next   = 1'b1;
        bl_out_next  = '1;
        blb_out_next = '1;
      end
      ACCESS: begin
        wl_next = 32'd1 << addr_lat;
        if (we_lat) begin
          bl_oe_next   = 1'b1;
          bl_out_next  = wdata_lat;
          blb_out_next = ~wdata_lat;
        end
      end
      RECOV:   rd_valid_next = !we_lat;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      wl        <= '0;
      bl_out    <= '0;
      blb_out   <= '0;
      bl_oe     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      wl        <= wl_next;
      bl_out    <= bl_out_next;
      blb_out   <= blb_out_next;
      bl_oe     <= bl_oe_next;
      rd_valid  <= rd_valid_next;
      req_ready <= req_ready_next;
      if (accept) begin
        we_lat    <= req_we;
        addr_lat  <= req_addr;
        wdata_lat <= req_wdata;
      end
      // A pair reading equal on BL and BLb means the cell did not resolve.
      if (sense) begin
        rd_data <= bl_in & ~blb_in;
        rd_err  <= ~&(bl_in ^ blb_in);
      end
    end
  end

endmodule

// File: tb/tb_impact_sram_ctrl.sv
// Self-checking bench: a default-parameter and a 1/1-cycle instance share stimulus
// and are compared every cycle against a cycle-count model of the access sequence.
module tb_impact_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] bl_in;
  logic [31:0] blb_in;

  logic [1:0]        ready_o;
  logic [1:0]        rv_o;
  logic [1:0]        err_o;
  logic [1:0]        oe_o;
  logic [1:0][31:0]  data_o;
  logic [1:0][31:0]  wl_o;
  logic [1:0][31:0]  bl_o;
  logic [1:0][31:0]  blb_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  impact_sram_ctrl #(.PRE_CYCLES(2), .WL_CYCLES(3), .ADDR_W(5)) dut_def (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(ready_o[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rv_o[0]), .rd_data(data_o[0]), .rd_err(err_o[0]),
    .wl(wl_o[0]), .bl_out(bl_o[0]), .blb_out(blb_o[0]), .bl_oe(oe_o[0]),
    .bl_in(bl_in), .blb_in(blb_in)
  );

  impact_sram_ctrl #(.PRE_CYCLES(1), .WL_CYCLES(1), .ADDR_W(5)) dut_fast (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(ready_o[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rv_o[1]), .rd_data(data_o[1]), .rd_err(err_o[1]),
    .wl(wl_o[1]), .bl_out(bl_o[1]), .blb_out(blb_o[1]), .bl_oe(oe_o[1]),
    .bl_in(bl_in), .blb_in(blb_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pc(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int wc(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Model: t counts cycles since the accepting edge; phase follows from t alone.
  bit          busy_m  [2];
  int          t_m     [2];
  bit          we_m    [2];
  logic [4:0]  addr_m  [2];
  logic [31:0] wdata_m [2];
  logic [31:0] rdata_m [2];
  bit          rerr_m  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        busy_m[k] = 0; t_m[k] = 0; we_m[k] = 0; addr_m[k] = '0;
        wdata_m[k] = '0; rdata_m[k] = '0; rerr_m[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!busy_m[k]) begin
          if (req_valid) begin
            busy_m[k] = 1; t_m[k] = 1;
            we_m[k] = req_we; addr_m[k] = req_addr; wdata_m[k] = req_wdata;
          end
        end else begin
          if (t_m[k] == pc(k) + wc(k) && !we_m[k]) begin
            for (int i = 0; i < 32; i++) rdata_m[k][i] = bl_in[i] && !blb_in[i];
            rerr_m[k] = 0;
            for (int i = 0; i < 32; i++) if (bl_in[i] == blb_in[i]) rerr_m[k] = 1;
          end
          if (t_m[k] == pc(k) + wc(k) + 1) busy_m[k] = 0;
          else t_m[k] = t_m[k] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] e_wl, e_bl, e_blb;
  bit          e_oe, e_rv;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        e_wl = '0; e_bl = '0; e_blb = '0; e_oe = 0; e_rv = 0;
        if (busy_m[k]) begin
          if (t_m[k] <= pc(k)) begin
            e_oe = 1; e_bl = '1; e_blb = '1;
          end else if (t_m[k] <= pc(k) + wc(k)) begin
            e_wl = 32'd1 << addr_m[k];
            if (we_m[k]) begin
              e_oe = 1; e_bl = wdata_m[k]; e_blb = ~wdata_m[k];
            end
          end else begin
            e_rv = !we_m[k];
          end
        end
        if (rst_n) checkOutput($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(!busy_m[k]));
        checkOutput($sformatf("wl%0d", k), wl_o[k], e_wl);
        checkOutput($sformatf("bl_oe%0d", k), 32'(oe_o[k]), 32'(e_oe));
        checkOutput($sformatf("bl_out%0d", k), bl_o[k], e_bl);
        checkOutput($sformatf("blb_out%0d", k), blb_o[k], e_blb);
        checkOutput($sformatf("rd_valid%0d", k), 32'(rv_o[k]), 32'(e_rv));
        checkOutput($sformatf("rd_data%0d", k), data_o[k], rdata_m[k]);
        checkOutput($sformatf("rd_err%0d", k), 32'(err_o[k]), 32'(rerr_m[k]));
        checkOutput($sformatf("bbm%0d", k),
                    32'(wl_o[k] != 0 && oe_o[k] && bl_o[k] == 32'hFFFF_FFFF), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(ready_o[0] && ready_o[1]) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkOutput("idle_timeout", 32'(ready_o), 32'h3);
  endtask

  task automatic applyStimulus();
    req_valid = ($urandom_range(0, 9) < 6);
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 5'($urandom);
    req_wdata = $urandom;
    bl_in     = $urandom;
    blb_in    = ($urandom_range(0, 3) == 0) ? $urandom : ~bl_in;
  endtask

  task automatic runRead(input logic [4:0] addr, input logic [31:0] bl, input logic [31:0] blb,
                         input logic [31:0] exp_d, input logic exp_e);
    waitIdle();
    bl_in = bl; blb_in = blb;
    req_we = 0; req_addr = addr; req_valid = 1;
    tick();
    req_valid = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c >= 3 && c <= 5) begin
        checkOutput("rd_wl", wl_o[0], 32'd1 << addr);
        checkOutput("rd_oe", 32'(oe_o[0]), 32'd0);
      end
      if (c == 3) begin
        checkOutput("fast_rv_c3", 32'(rv_o[1]), 32'd1);
        checkOutput("fast_data_c3", data_o[1], exp_d);
      end
      if (c == 6) begin
        checkOutput("rd_rv_c6", 32'(rv_o[0]), 32'd1);
        checkOutput("rd_data_c6", data_o[0], exp_d);
        checkOutput("rd_err_c6", 32'(err_o[0]), 32'(exp_e));
      end
      if (c == 7) begin
        checkOutput("rd_rv_c7", 32'(rv_o[0]), 32'd0);
        checkOutput("rd_ready_c7", 32'(ready_o[0]), 32'd1);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    bl_in = '0; blb_in = '0;
    repeat (3) tick();
    cmp_en = 1;
    checkOutput("reset_wl", wl_o[0], 32'd0);
    checkOutput("reset_oe", 32'(oe_o[0]), 32'd0);
    checkOutput("reset_rv", 32'(rv_o[0]), 32'd0);
    #2 rst_n = 1;
    tick();
    checkOutput("reset_ready", 32'(ready_o[0]), 32'd1);

    // Write addr 5 with literal expectations per cycle.
    waitIdle();
    req_we = 1; req_addr = 5'd5; req_wdata = 32'hA5A5_0F0F; req_valid = 1;
    tick();
    req_valid = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= 2) begin
        checkOutput("wr_pre_oe", 32'(oe_o[0]), 32'd1);
        checkOutput("wr_pre_bl", bl_o[0], 32'hFFFF_FFFF);
        checkOutput("wr_pre_blb", blb_o[0], 32'hFFFF_FFFF);
        checkOutput("wr_pre_wl", wl_o[0], 32'd0);
      end else if (c <= 5) begin
        checkOutput("wr_acc_wl", wl_o[0], 32'h0000_0020);
        checkOutput("wr_acc_bl", bl_o[0], 32'hA5A5_0F0F);
        checkOutput("wr_acc_blb", blb_o[0], 32'h5A5A_F0F0);
      end else if (c == 6) begin
        checkOutput("wr_rec_wl", wl_o[0], 32'd0);
        checkOutput("wr_rec_rv", 32'(rv_o[0]), 32'd0);
      end else begin
        checkOutput("wr_ready_c7", 32'(ready_o[0]), 32'd1);
      end
      tick();
    end

    runRead(5'd31, 32'h1234_5678, ~32'h1234_5678, 32'h1234_5678, 1'b0);
    checkOutput("rd31_wl_lit", 32'd1 << 5'd31, 32'h8000_0000 & {32{ready_o[0]}});
    runRead(5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    runRead(5'd9, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);

    // Back-to-back: write addr 0 then read addr 1 with req_valid held.
    waitIdle();
    req_valid = 1; req_we = 1; req_addr = 5'd0; req_wdata = $urandom;
    tick();
    req_we = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 6) checkOutput("b2b_busy", 32'(ready_o[0]), 32'd0);
      if (c >= 3 && c <= 5) checkOutput("b2b_wl_addr0", wl_o[0], 32'd1);
      if (c == 7) checkOutput("b2b_ready7", 32'(ready_o[0]), 32'd1);
      if (c == 8) begin
        checkOutput("b2b_accept7", 32'(ready_o[0]), 32'd0);
        checkOutput("b2b_pre_oe", 32'(oe_o[0]), 32'd1);
        req_valid = 0;
      end
      if (c >= 10) checkOutput("b2b_wl_addr1", wl_o[0], 32'd2);
      if (c <= 5) req_addr = 5'($urandom);
      else        req_addr = 5'd1;
      tick();
    end

    // Asynchronous reset in the middle of a write ACCESS to addr 7.
    waitIdle();
    req_valid = 1; req_we = 1; req_addr = 5'd7; req_wdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 0;
    tick(); tick();
    checkOutput("rst_acc_wl", wl_o[0], 32'h0000_0080);
    tick();
    #2 rst_n = 0;
    #1;
    checkOutput("rst_async_wl", wl_o[0], 32'd0);
    checkOutput("rst_async_oe", 32'(oe_o[0]), 32'd0);
    checkOutput("rst_async_rv", 32'(rv_o[0]), 32'd0);
    tick();
    #2 rst_n = 1;
    tick();
    checkOutput("rst_ready", 32'(ready_o[0]), 32'd1);
    runRead(5'd2, 32'hCAFE_0001, ~32'hCAFE_0001, 32'hCAFE_0001, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      tick();
    end
    req_valid = 0;
    waitIdle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
